// File: rtl/spec_rat.sv
// Speculative front-end register alias table: arch->phys map with per-arch ready bits,
// CDB wakeups, decode renames and full-state restore from the branch checkpoint queue.
module spec_rat #(
   parameter int PHYS_W = 6,
   parameter int N_ARCH = 32
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           flush_by_branch,
   input  logic [N_ARCH-1:0][PHYS_W-1:0]  ckpt_map_in,
   input  logic [N_ARCH-1:0]              ckpt_valid_in,
   input  logic                           rename_en,
   input  logic [$clog2(N_ARCH)-1:0]      rename_arch,
   input  logic [PHYS_W-1:0]              rename_phys,
   input  logic [$clog2(N_ARCH)-1:0]      rs1_arch,
   input  logic [$clog2(N_ARCH)-1:0]      rs2_arch,
   output logic [PHYS_W-1:0]              rs1_phys,
   output logic [PHYS_W-1:0]              rs2_phys,
   output logic                           rs1_ready,
   output logic                           rs2_ready,
   input  logic [3:0]                     cdb_valid,
   input  logic [3:0][$clog2(N_ARCH)-1:0] cdb_arch,
   input  logic [3:0][PHYS_W-1:0]         cdb_phys,
   output logic [N_ARCH-1:0][PHYS_W-1:0]  map_out,
   output logic [N_ARCH-1:0]              valid_map_out,
   output logic                           rat_ready
);
   localparam int AW = $clog2(N_ARCH);
   localparam logic [0:0] RUN     = 1'b0;
   localparam logic [0:0] RECOVER = 1'b1;

   logic [0:0]                    state_q, state_d;
   logic [N_ARCH-1:0][PHYS_W-1:0] map_q, map_d, src_map;
   logic [N_ARCH-1:0]             valid_q, valid_d, src_valid;

   function automatic logic cdb_hit(input logic [AW-1:0] arch, input logic [PHYS_W-1:0] tag);
      logic hit;
      hit = 1'b0;
      for (int p = 0; p < 4; p++)
         if (cdb_valid[p] && cdb_arch[p] == arch && cdb_phys[p] == tag) hit = 1'b1;
      return hit;
   endfunction

   always_comb begin
      // A flush replaces the base state wholesale; wakeups then match against the checkpoint map.
      src_map   = flush_by_branch ? ckpt_map_in   : map_q;
      src_valid = flush_by_branch ? ckpt_valid_in : valid_q;
      map_d     = src_map;
      valid_d   = src_valid;
      for (int p = 0; p < 4; p++)
         if (cdb_valid[p] && cdb_arch[p] != '0 && src_map[cdb_arch[p]] == cdb_phys[p])
            valid_d[cdb_arch[p]] = 1'b1;
      // Rename is applied after wakeup so it wins on the same arch register.
      if (!flush_by_branch && state_q == RUN && rename_en && rename_arch != '0) begin
         map_d[rename_arch]   = rename_phys;
         valid_d[rename_arch] = 1'b0;
      end
      map_d[0]   = '0;
      valid_d[0] = 1'b1;
      state_d    = flush_by_branch ? RECOVER : RUN;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_ARCH; i++) map_q[i] <= PHYS_W'(i);
         valid_q <= '1;
         state_q <= RUN;
      end else begin
         map_q   <= map_d;
         valid_q <= valid_d;
         state_q <= state_d;
      end
   end

   assign rs1_phys      = map_q[rs1_arch];
   assign rs2_phys      = map_q[rs2_arch];
   assign rs1_ready     = valid_q[rs1_arch] | cdb_hit(rs1_arch, map_q[rs1_arch]);
   assign rs2_ready     = valid_q[rs2_arch] | cdb_hit(rs2_arch, map_q[rs2_arch]);
   assign map_out       = map_q;
   assign valid_map_out = valid_q;
   assign rat_ready     = (state_q == RUN);
endmodule

// File: tb/tb_spec_rat.sv
// Bench for spec_rat: directed vector table for the corner cases, then random traffic
// checked against an array-based reference model of the alias table.
module tb_spec_rat;
   logic              clk = 1'b0;
   logic              rst, flush_by_branch, rename_en;
   logic [31:0][5:0]  ckpt_map_in;
   logic [31:0]       ckpt_valid_in;
   logic [4:0]        rename_arch, rs1_arch, rs2_arch;
   logic [5:0]        rename_phys, rs1_phys, rs2_phys;
   logic              rs1_ready, rs2_ready, rat_ready;
   logic [3:0]        cdb_valid;
   logic [3:0][4:0]   cdb_arch;
   logic [3:0][5:0]   cdb_phys;
   logic [31:0][5:0]  map_out;
   logic [31:0]       valid_map_out;

   spec_rat #(.PHYS_W(6), .N_ARCH(32)) dut (
      .clk(clk), .rst(rst), .flush_by_branch(flush_by_branch),
      .ckpt_map_in(ckpt_map_in), .ckpt_valid_in(ckpt_valid_in),
      .rename_en(rename_en), .rename_arch(rename_arch), .rename_phys(rename_phys),
      .rs1_arch(rs1_arch), .rs2_arch(rs2_arch), .rs1_phys(rs1_phys), .rs2_phys(rs2_phys),
      .rs1_ready(rs1_ready), .rs2_ready(rs2_ready),
      .cdb_valid(cdb_valid), .cdb_arch(cdb_arch), .cdb_phys(cdb_phys),
      .map_out(map_out), .valid_map_out(valid_map_out), .rat_ready(rat_ready));

   always #5 clk = ~clk;

   int n_pass = 0, n_tot = 0;

   // Reference model: plain arrays of the architectural view.
   int m_map[32];
   bit m_vld[32];
   bit m_rec;

   task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic bit bypass(input int rs);
      for (int p = 0; p < 4; p++)
         if (cdb_valid[p] && int'(cdb_arch[p]) == rs && int'(cdb_phys[p]) == m_map[rs]) return 1;
      return 0;
   endfunction

   task automatic model_check();
      logic [31:0][5:0] em;
      logic [31:0]      ev;
      for (int i = 0; i < 32; i++) begin
         em[i] = 6'(m_map[i]);
         ev[i] = m_vld[i];
      end
      chk("model_rs1_phys", 192'(rs1_phys), 192'(m_map[rs1_arch]));
      chk("model_rs1_ready", 192'(rs1_ready), 192'(m_vld[rs1_arch] | bypass(int'(rs1_arch))));
      chk("model_rs2_phys", 192'(rs2_phys), 192'(m_map[rs2_arch]));
      chk("model_rs2_ready", 192'(rs2_ready), 192'(m_vld[rs2_arch] | bypass(int'(rs2_arch))));
      chk("model_rat_ready", 192'(rat_ready), 192'(!m_rec));
      chk("model_map_out", 192'(map_out), 192'(em));
      chk("model_valid_map", 192'(valid_map_out), 192'(ev));
   endtask

   // Apply the clock-edge rules to the model using the inputs currently driven.
   task automatic model_update();
      int  nm[32];
      bit  nv[32];
      if (rst) begin
         for (int i = 0; i < 32; i++) begin m_map[i] = i; m_vld[i] = 1; end
         m_rec = 0;
         return;
      end
      for (int i = 0; i < 32; i++) begin
         nm[i] = flush_by_branch ? int'(ckpt_map_in[i]) : m_map[i];
         nv[i] = flush_by_branch ? ckpt_valid_in[i] : m_vld[i];
      end
      for (int p = 0; p < 4; p++)
         if (cdb_valid[p] && cdb_arch[p] != 0 && nm[cdb_arch[p]] == int'(cdb_phys[p]))
            nv[cdb_arch[p]] = 1;
      if (!flush_by_branch && !m_rec && rename_en && rename_arch != 0) begin
         nm[rename_arch] = int'(rename_phys);
         nv[rename_arch] = 0;
      end
      nm[0] = 0; nv[0] = 1;
      m_map = nm; m_vld = nv;
      m_rec = flush_by_branch;
   endtask

   typedef struct {
      bit rst, fl, ren;
      int ra, rp, cport, ca, cp, rs1, rs2;
      int e1p, e1r, e2p, e2r, erdy;
   } vec_t;

   function automatic vec_t v(bit r, bit fl, bit ren, int ra, int rp, int cport, int ca, int cp,
                              int rs1, int rs2, int e1p, int e1r, int e2p, int e2r, int erdy);
      vec_t t;
      t.rst = r; t.fl = fl; t.ren = ren; t.ra = ra; t.rp = rp;
      t.cport = cport; t.ca = ca; t.cp = cp; t.rs1 = rs1; t.rs2 = rs2;
      t.e1p = e1p; t.e1r = e1r; t.e2p = e2p; t.e2r = e2r; t.erdy = erdy;
      return t;
   endfunction

   task automatic drive_vec(input vec_t t);
      rst = t.rst; flush_by_branch = t.fl; rename_en = t.ren;
      rename_arch = 5'(t.ra); rename_phys = 6'(t.rp);
      rs1_arch = 5'(t.rs1); rs2_arch = 5'(t.rs2);
      cdb_valid = '0; cdb_arch = '0; cdb_phys = '0;
      if (t.cport >= 0) begin
         cdb_valid[t.cport] = 1'b1;
         cdb_arch[t.cport]  = 5'(t.ca);
         cdb_phys[t.cport]  = 6'(t.cp);
      end
   endtask

   vec_t tbl[19];

   initial begin
      // Checkpoint: map[i]=63-i with overrides; entry 0 and valid bit 0 deliberately wrong.
      for (int i = 0; i < 32; i++) ckpt_map_in[i] = 6'(63 - i);
      ckpt_map_in[0] = 6'd7; ckpt_map_in[9] = 6'd33; ckpt_map_in[2] = 6'd20;
      ckpt_valid_in = 32'h5555_5554;

      //            rst fl ren ra rp  port ca cp  rs1 rs2  e1p e1r e2p e2r rdy
      tbl[0]  = v(0, 0, 0, 0, 0,  -1, 0, 0,   5, 0,    5, 1,  0, 1, 1);
      tbl[1]  = v(0, 0, 1, 3, 40, -1, 0, 0,   3, 7,    3, 1,  7, 1, 1);
      tbl[2]  = v(0, 0, 0, 0, 0,  -1, 0, 0,   3, 3,   40, 0, 40, 0, 1);
      tbl[3]  = v(0, 0, 0, 0, 0,   0, 3, 40,  3, 4,   40, 1,  4, 1, 1);
      tbl[4]  = v(0, 0, 1, 3, 41,  1, 3, 40,  3, 3,   40, 1, 40, 1, 1);
      tbl[5]  = v(0, 0, 0, 0, 0,   2, 3, 3,   3, 3,   41, 0, 41, 0, 1);
      tbl[6]  = v(0, 0, 0, 0, 0,  -1, 0, 0,   3, 0,   41, 0,  0, 1, 1);
      tbl[7]  = v(0, 0, 1, 4, 50,  2, 4, 4,   4, 0,    4, 1,  0, 1, 1);
      tbl[8]  = v(0, 0, 1, 0, 60, -1, 0, 0,   4, 0,   50, 0,  0, 1, 1);
      tbl[9]  = v(0, 0, 0, 0, 0,  -1, 0, 0,   0, 4,    0, 1, 50, 0, 1);
      tbl[10] = v(0, 1, 1, 10, 12, 3, 9, 33,  9, 10,   9, 1, 10, 1, 1);
      tbl[11] = v(0, 0, 0, 0, 0,  -1, 0, 0,   9, 10,  33, 1, 53, 1, 0);
      tbl[12] = v(0, 0, 0, 0, 0,  -1, 0, 0,   0, 3,    0, 1, 60, 0, 1);
      tbl[13] = v(0, 1, 0, 0, 0,  -1, 0, 0,   2, 1,   20, 1, 62, 0, 1);
      tbl[14] = v(0, 1, 0, 0, 0,  -1, 0, 0,   2, 1,   20, 1, 62, 0, 0);
      tbl[15] = v(0, 0, 1, 5, 45, -1, 0, 0,   5, 0,   58, 0,  0, 1, 0);
      tbl[16] = v(0, 0, 0, 0, 0,  -1, 0, 0,   5, 0,   58, 0,  0, 1, 1);
      tbl[17] = v(1, 1, 1, 6, 30, -1, 0, 0,   6, 0,   57, 1,  0, 1, 1);
      tbl[18] = v(0, 0, 0, 0, 0,  -1, 0, 0,   6, 9,    6, 1,  9, 1, 1);

      drive_vec(v(1, 0, 0, 0, 0, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(posedge clk); model_update();
      @(negedge clk);

      for (int k = 0; k < 19; k++) begin
         drive_vec(tbl[k]);
         #1;
         chk($sformatf("v%0d_rs1_phys", k),  192'(rs1_phys),  192'(tbl[k].e1p));
         chk($sformatf("v%0d_rs1_ready", k), 192'(rs1_ready), 192'(tbl[k].e1r));
         chk($sformatf("v%0d_rs2_phys", k),  192'(rs2_phys),  192'(tbl[k].e2p));
         chk($sformatf("v%0d_rs2_ready", k), 192'(rs2_ready), 192'(tbl[k].e2r));
         chk($sformatf("v%0d_rat_ready", k), 192'(rat_ready), 192'(tbl[k].erdy));
         model_check();
         @(posedge clk); model_update();
         @(negedge clk);
      end
      #1;
      chk("reset_map7", 192'(map_out[7]), 192'(7));
      chk("reset_valid_all", 192'(valid_map_out), 192'(32'hFFFF_FFFF));

      // Random traffic; CDB tags are biased toward the live (or checkpoint) mapping to hit wakeups.
      for (int k = 0; k < 3000; k++) begin
         rst             = ($urandom_range(0, 99) == 0);
         flush_by_branch = ($urandom_range(0, 7) == 0);
         rename_en       = $urandom_range(0, 1) == 1;
         rename_arch     = 5'($urandom_range(0, 31));
         rename_phys     = 6'($urandom_range(0, 63));
         rs1_arch        = 5'($urandom_range(0, 31));
         rs2_arch        = ($urandom_range(0, 2) == 0) ? rename_arch : 5'($urandom_range(0, 31));
         ckpt_valid_in   = $urandom;
         for (int i = 0; i < 32; i++) ckpt_map_in[i] = 6'($urandom_range(0, 63));
         for (int p = 0; p < 4; p++) begin
            cdb_valid[p] = $urandom_range(0, 1) == 1;
            cdb_arch[p]  = ($urandom_range(0, 1) == 1) ? rs1_arch : 5'($urandom_range(0, 31));
            case ($urandom_range(0, 2))
               0:       cdb_phys[p] = 6'(m_map[cdb_arch[p]]);
               1:       cdb_phys[p] = ckpt_map_in[cdb_arch[p]];
               default: cdb_phys[p] = 6'($urandom_range(0, 63));
            endcase
         end
         #1;
         model_check();
         @(posedge clk); model_update();
         @(negedge clk);
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule

// File: doc/spec_rat.md
Name: spec_rat

Overview:
- Speculative register alias table (front-end RAT) for the out-of-order core.
- Maps 32 architectural registers to physical tags and tracks a per-arch ready bit.
- Accepts renames from decode, wakeups from the four CDB ports, and full-state restores from the branch checkpoint queue when a mispredict is flushed.
- Exports its live map and valid vector so the checkpoint queue can snapshot them.

Parameters:
- PHYS_W, 6, width of a physical register tag (64 physical registers).
- N_ARCH, 32, number of architectural registers (fixed, listed for clarity).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- flush_by_branch  in  1  mispredict restore strobe.
- ckpt_map_in  in  32 x PHYS_W  checkpoint map to restore; valid only when flush_by_branch=1.
- ckpt_valid_in  in  32  checkpoint ready vector; valid only when flush_by_branch=1.
- rename_en  in  1  decode allocates a new mapping this cycle.
- rename_arch  in  5  destination architectural register.
- rename_phys  in  PHYS_W  tag popped from the free list.
- rs1_arch, rs2_arch  in  5 each  source lookups.
- rs1_phys, rs2_phys  out  PHYS_W each  current mapping of each source.
- rs1_ready, rs2_ready  out  1 each  source value available.
- cdb_valid  in  4  per-port valid (order: add, branch, md, mem).
- cdb_arch  in  4 x 5  per-port architectural destination.
- cdb_phys  in  4 x PHYS_W  per-port physical destination.
- map_out  out  32 x PHYS_W  registered map, for checkpoint capture.
- valid_map_out  out  32  registered ready vector, for checkpoint capture.
- rat_ready  out  1  rename accepted this cycle; drives decode stall.

Behaviour:
- Reset:
  - map[i] = i for every i.
  - valid_map = all ones.
  - state = RUN; rat_ready = 1.
  - rst has priority over every other input.
- FSM has two states, RUN and RECOVER.
  - RUN -> RECOVER on flush_by_branch.
  - RECOVER -> RUN after one cycle, unless flush_by_branch is asserted again; a flush in RECOVER reloads and stays in RECOVER one more cycle.
  - rat_ready = (state == RUN); combinational from state only.
- x0 handling:
  - map[0] = 0 and valid[0] = 1 at all times.
  - Renames and CDB writes targeting arch 0 are ignored.
- Rename, in RUN only, when rename_en = 1 and rename_arch != 0:
  - Next cycle, map[rename_arch] = rename_phys and valid[rename_arch] = 0.
  - rename_en in RECOVER, or coincident with a flush, is dropped.
- CDB wakeup, evaluated for each port independently (multiple ports may hit different arch regs in the same cycle):
  - If cdb_valid, arch != 0, and the registered map[arch] == phys, then valid[arch] = 1 next cycle.
  - A tag mismatch means the mapping is stale; no change.
  - A same-cycle rename of the same arch wins; the result is valid = 0 with the new tag.
- Lookups are combinational, 0-cycle latency:
  - rsN_phys = map[rsN_arch].
  - rsN_ready = valid[rsN_arch] OR a same-cycle CDB bypass. The bypass fires when any valid CDB port has arch == rsN_arch and phys == map[rsN_arch].
  - rsN_arch = 0 gives phys 0, ready 1.
  - Lookups do not see a same-cycle rename; decode resolves intra-bundle dependencies.
- Restore, on flush_by_branch (any state):
  - Next cycle, map = ckpt_map_in with entry 0 forced to 0.
  - Next cycle, valid = ckpt_valid_in with bit 0 forced to 1.
  - Same-cycle CDB broadcasts are folded in: a port with ckpt_map_in[arch] == phys sets that valid bit.
  - The registered map is discarded.
- CDB wakeups continue in RECOVER against the restored map.
- map_out and valid_map_out are the registered state only; same-cycle rename and CDB effects are the checkpoint writer's responsibility.

Test Plan:
1. Reset, then look up rs1=5, rs2=0 -> rs1_phys=5, rs1_ready=1, rs2_phys=0, rs2_ready=1, rat_ready=1, map_out[7]=7.
2. Rename arch3 -> phys40; next cycle rs1=3 -> phys 40, ready 0. Then CDB add (arch3, phys40) -> ready 1 same cycle (bypass) and valid_map_out[3]=1 next cycle. A later CDB (arch3, phys3) leaves valid unchanged.
3. Same cycle: rename arch4 -> phys50 and CDB md (arch4, phys4) -> next cycle map[4]=50, valid[4]=0. Rename arch0 -> phys60 -> map[0]=0, valid[0]=1.
4. Flush with ckpt_map[9]=33, ckpt_valid[9]=0, CDB mem (arch9, phys33) the same cycle, plus rename_en for arch10 -> next cycle map[9]=33, valid[9]=1, map[10] unchanged from the checkpoint, rat_ready=0 for exactly one cycle, then 1.
5. Flush, then a second flush during RECOVER with ckpt_map[2]=20 -> map[2]=20, rat_ready stays 0 one more cycle. A rename issued in RECOVER is dropped.
6. rst asserted together with flush and rename -> reset state: map[i]=i, valid all 1, RUN.
